// File: rtl/pe_inject_arbiter.sv
// Round-robin arbiter feeding one HNoC PE injection port through a single-entry output register.
// Optional per-requester transfer counters are enabled by defining PE_INJECT_ARBITER_STATS_EN.
module pe_inject_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned DW    = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ*DW-1:0]    i_req_data,
   input  logic [N_REQ-1:0]       i_req_valid,
   output logic [N_REQ-1:0]       o_req_ready,
   output logic [DW-1:0]          o_data,
   output logic                   o_data_valid,
   input  logic                   i_data_ready,
   output logic [N_REQ-1:0]       o_grant
`ifdef PE_INJECT_ARBITER_STATS_EN
   ,
   output logic [N_REQ*16-1:0]    o_grant_cnt
`endif
);

   localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t            state, state_nxt;
   logic              can_accept;
   logic              found;
   logic              xfer;
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     sel_idx;
   logic [N_REQ-1:0]  sel_oh;
   logic [DW-1:0]     sel_data;
   int unsigned       idx;

   // Search starts at ptr and wraps, so the first hit is the round-robin winner.
   always_comb begin
      found    = 1'b0;
      sel_idx  = '0;
      sel_oh   = '0;
      sel_data = '0;
      idx      = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = (32'(ptr) + i) % N_REQ;
         if (!found && i_req_valid[idx]) begin
            found       = 1'b1;
            sel_idx     = PW'(idx);
            sel_oh[idx] = 1'b1;
            sel_data    = i_req_data[idx*DW +: DW];
         end
      end

      can_accept  = (state == EMPTY) || i_data_ready;
      xfer        = can_accept && found && !rst;
      o_req_ready = xfer ? sel_oh : '0;

      state_nxt = state;
      case (state)
         EMPTY:   if (xfer) state_nxt = FULL;
         FULL:    if (i_data_ready && !xfer) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   assign o_data_valid = (state == FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         o_data  <= '0;
         o_grant <= '0;
         ptr     <= '0;
      end else if (xfer) begin
         o_data  <= sel_data;
         o_grant <= sel_oh;
         ptr     <= (sel_idx == PW'(N_REQ - 1)) ? '0 : sel_idx + PW'(1);
      end else if (state == FULL && i_data_ready) begin
         o_grant <= '0;
      end
   end

`ifdef PE_INJECT_ARBITER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         o_grant_cnt <= '0;
      end else begin
         for (int unsigned k = 0; k < N_REQ; k++) begin
            if (xfer && sel_oh[k] && (o_grant_cnt[k*16 +: 16] != 16'hFFFF))
               o_grant_cnt[k*16 +: 16] <= o_grant_cnt[k*16 +: 16] + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pe_inject_arbiter.sv
// Directed, table-driven bench for pe_inject_arbiter (N_REQ=4, DW=32).
module tb_pe_inject_arbiter;

   logic          clk = 1'b0;
   logic          rst;
   logic [127:0]  i_req_data;
   logic [3:0]    i_req_valid;
   logic [3:0]    o_req_ready;
   logic [31:0]   o_data;
   logic          o_data_valid;
   logic          i_data_ready;
   logic [3:0]    o_grant;
`ifdef PE_INJECT_ARBITER_STATS_EN
   logic [63:0]   o_grant_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pe_inject_arbiter #(.N_REQ(4), .DW(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_req_data   (i_req_data),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .o_data       (o_data),
      .o_data_valid (o_data_valid),
      .i_data_ready (i_data_ready),
      .o_grant      (o_grant)
`ifdef PE_INJECT_ARBITER_STATS_EN
      ,
      .o_grant_cnt  (o_grant_cnt)
`endif
   );

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic        ready;
      logic [3:0]  rdy;    // expected o_req_ready before the edge
      logic        dv;     // expected outputs after the edge
      logic [31:0] data;
      logic [3:0]  grant;
   } vec_t;

   vec_t vt[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic edge_settle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; i_req_valid = 4'h0; i_data_ready = 1'b0;
      edge_settle();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      i_req_valid  = 4'h0;
      i_data_ready = 1'b0;
      i_req_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

      //         rst   valid  rdy   req_rdy dv    data         grant
      vt[0]  = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0,  4'h0};
      vt[1]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 32'h0,  4'h0};
      vt[2]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 32'hA0, 4'h1};
      vt[3]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 32'hA1, 4'h2};
      vt[4]  = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 32'hA2, 4'h4};
      vt[5]  = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 32'hA3, 4'h8};
      vt[6]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 32'hA0, 4'h1};
      vt[7]  = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 32'hA0, 4'h1};
      vt[8]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 32'h0,  4'h0};
      vt[9]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0,  4'h0};
      vt[10] = '{1'b0, 4'h1, 1'b0, 4'h1, 1'b1, 32'hA0, 4'h1};
      vt[11] = '{1'b0, 4'hC, 1'b1, 4'h4, 1'b1, 32'hA2, 4'h4};
      vt[12] = '{1'b0, 4'h3, 1'b1, 4'h1, 1'b1, 32'hA0, 4'h1};
      vt[13] = '{1'b0, 4'h3, 1'b1, 4'h2, 1'b1, 32'hA1, 4'h2};
      vt[14] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 32'h0,  4'h0};

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         rst = vt[i].rst; i_req_valid = vt[i].valid; i_data_ready = vt[i].ready;
         #1;
         chk($sformatf("vec%0d req_ready", i), 32'(o_req_ready), 32'(vt[i].rdy));
         edge_settle();
         chk($sformatf("vec%0d data_valid", i), 32'(o_data_valid), 32'(vt[i].dv));
         chk($sformatf("vec%0d grant", i), 32'(o_grant), 32'(vt[i].grant));
         if (vt[i].dv || vt[i].rst)
            chk($sformatf("vec%0d data", i), o_data, vt[i].data);
      end

      // Single flit from requester 2 held under backpressure, then drained.
      do_reset();
      i_req_data[95:64] = 32'h0000_0025;
      i_req_valid = 4'b0100;
      #1;
      chk("stall first ready", 32'(o_req_ready), 32'h4);
      edge_settle();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         i_req_valid = 4'h0;
         #1;
         chk("stall ready", 32'(o_req_ready), 32'h0);
         chk("stall valid", 32'(o_data_valid), 32'h1);
         chk("stall data", o_data, 32'h25);
         chk("stall grant", 32'(o_grant), 32'h4);
         edge_settle();
      end
      @(negedge clk);
      i_data_ready = 1'b1;
      edge_settle();
      chk("drain valid", 32'(o_data_valid), 32'h0);
      chk("drain grant", 32'(o_grant), 32'h0);

      // Requester 1 streaming: refill every cycle with no bubble.
      do_reset();
      i_data_ready = 1'b1;
      i_req_valid  = 4'b0010;
      for (int n = 0; n < 8; n++) begin
         if (n != 0) @(negedge clk);
         i_req_data[63:32] = 32'h100 + 32'(n);
         #1;
         chk("stream ready", 32'(o_req_ready), 32'h2);
         edge_settle();
         chk("stream valid", 32'(o_data_valid), 32'h1);
         chk("stream data", o_data, 32'h100 + 32'(n));
         chk("stream grant", 32'(o_grant), 32'h2);
      end

      // Reset while holding requester 3's flit; requester 3 re-granted afterwards.
      do_reset();
      i_req_data  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      i_req_valid = 4'b1000;
      i_data_ready = 1'b0;
      edge_settle();
      chk("r3 held grant", 32'(o_grant), 32'h8);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("r3 rst ready", 32'(o_req_ready), 32'h0);
      edge_settle();
      chk("r3 rst valid", 32'(o_data_valid), 32'h0);
      chk("r3 rst data", o_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("r3 regrant ready", 32'(o_req_ready), 32'h8);
      edge_settle();
      chk("r3 regrant valid", 32'(o_data_valid), 32'h1);
      chk("r3 regrant grant", 32'(o_grant), 32'h8);
      chk("r3 regrant data", o_data, 32'hA3);

`ifdef PE_INJECT_ARBITER_STATS_EN
      do_reset();
      i_req_valid  = 4'b0001;
      i_data_ready = 1'b1;
      repeat (70000) @(posedge clk);
      #1;
      chk("cnt0 saturated", 32'(o_grant_cnt[15:0]), 32'hFFFF);
      chk("cnt others zero", 32'(o_grant_cnt[63:16] != 48'h0), 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pe_inject_arbiter.md
PE_INJECT_ARBITER -- requirements
Module: pe_inject_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, is the number of requesters sharing one HNoC PE injection port (legal 2..8).
REQ-002 Parameter DW, default 32, is the flit width in bits.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_req_data  input  N_REQ*DW  requester flits; requester k occupies bits [k*DW +: DW].
REQ-006 i_req_valid  input  N_REQ  per-requester valid.
REQ-007 o_req_ready  output  N_REQ  per-requester ready; at most one bit set.
REQ-008 o_data  output  DW  flit to HNoC i_pe_data port.
REQ-009 o_data_valid  output  1  flit valid to HNoC.
REQ-010 i_data_ready  input  1  HNoC o_pe_data_ready.
REQ-011 o_grant  output  N_REQ  one-hot index of the requester whose flit is held in the output register; zero when empty.

Function
REQ-012 The block SHALL contain a single-entry output register with two states: EMPTY (o_data_valid=0) and FULL (o_data_valid=1).
REQ-013 The register SHALL be able to accept a flit when EMPTY, or when FULL and i_data_ready=1 in the same cycle (drain-and-refill).
REQ-014 When it can accept, the arbiter SHALL select the first requester with i_req_valid=1, searching round-robin from pointer ptr upward with wrap from N_REQ-1 to 0.
REQ-015 o_req_ready SHALL be combinational: only the selected requester's bit is 1, and only while the register can accept; otherwise all bits are 0.
REQ-016 A transfer from requester k occurs when i_req_valid[k] and o_req_ready[k] are both 1; on that edge o_data<=flit k, o_data_valid<=1, o_grant<=one-hot(k), ptr<=(k+1) mod N_REQ.
REQ-017 Latency from requester transfer to o_data_valid SHALL be exactly 1 cycle; sustained throughput SHALL be 1 flit per cycle while i_data_ready=1.
REQ-018 When FULL and i_data_ready=1 and no requester is valid, the register SHALL go EMPTY and o_grant SHALL become 0.
REQ-019 When FULL and i_data_ready=0, o_data, o_data_valid and o_grant SHALL hold unchanged and all o_req_ready SHALL be 0.
REQ-020 ptr SHALL advance only on a transfer; idle cycles and stalls SHALL NOT change it.
REQ-021 With all N_REQ requesters continuously valid and no backpressure, grants SHALL rotate 0,1,...,N_REQ-1,0,...; no requester SHALL wait more than N_REQ-1 transfers.
REQ-022 Flit contents SHALL pass unmodified; the block SHALL NOT inspect the address field.

Reset
REQ-023 While rst=1: o_data_valid=0, o_data=0, o_grant=0, ptr=0, o_req_ready=0, and any held flit is discarded.
REQ-024 Reset asserted mid-stall SHALL drop the held flit and leave the requester's valid unacknowledged; it is re-arbitrated from ptr=0 after reset.

Configuration
REQ-025 Macro PE_INJECT_ARBITER_STATS_EN, when defined, SHALL add output o_grant_cnt (N_REQ*16 bits): per-requester 16-bit transfer counters, cleared by rst, incremented on each transfer, saturating at 16'hFFFF.
REQ-026 Without PE_INJECT_ARBITER_STATS_EN, o_grant_cnt and all counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Reset, then all 4 requesters valid with data 32'hA0..A3, i_data_ready=1 -> o_data sequence A0,A1,A2,A3,A0 on consecutive cycles, first one cycle after rst deasserts.
REQ-028 Only requester 2 valid, data 32'h0000_0025, i_data_ready=0 for 5 cycles -> o_data_valid=1, o_data=32'h25, o_grant=4'b0100 stable 5 cycles, o_req_ready=0; one cycle after ready rises, o_data_valid=0.
REQ-029 ptr=3 after granting requester 2, then requesters 0 and 1 valid -> requester 0 granted first (wrap), then requester 1.
REQ-030 Requester 1 streaming with i_data_ready=1 -> back-to-back drain-and-refill, o_data_valid continuously 1, no bubble.
REQ-031 rst asserted for one cycle while FULL with requester 3's flit -> o_data_valid=0 next cycle; after release, requester 3 (still valid) re-granted with o_grant=4'b1000.
REQ-032 With PE_INJECT_ARBITER_STATS_EN, 70000 transfers from requester 0 -> o_grant_cnt[15:0]=16'hFFFF, other counters 0.
